// File: rtl/aes_pkg.sv
// aes_pkg: shared types and constants for the AES byte-stream front end.
package aes_pkg;
    localparam int AES_BLK_BYTES = 16;
    typedef logic [7:0] byte_t;
    typedef byte_t block_t [AES_BLK_BYTES-1:0];
    typedef enum logic [1:0] {LOAD, ISSUE, WAIT, DRAIN} st_e;
endpackage

// File: rtl/aes_block_ser.sv
// aes_block_ser: parallel-in block to valid/ready byte stream, element 0 first, last flag on the final byte.
module aes_block_ser
    import aes_pkg::*;
(
    input  logic       sclk,
    input  logic       srst_n,
    input  logic       load,
    input  logic [7:0] blk [AES_BLK_BYTES-1:0],
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_last,
    input  logic       out_ready,
    output logic       done
);
    localparam int IW = $clog2(AES_BLK_BYTES);
    localparam logic [IW-1:0] IDX_PRE_LAST = IW'(AES_BLK_BYTES - 2);
    block_t        res_reg;
    logic [IW-1:0] idx;
    logic          take;
    assign take = out_valid & out_ready;
    assign done = take & out_last;
    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            res_reg   <= '{default: '0};
            idx       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (load) begin
            res_reg   <= blk;
            idx       <= '0;
            out_data  <= blk[0];
            out_valid <= 1'b1;
            out_last  <= 1'b0;
        end else if (take) begin
            idx       <= idx + 1'b1;
            out_data  <= out_last ? out_data : res_reg[idx + 1'b1];
            out_valid <= !out_last;
            out_last  <= idx == IDX_PRE_LAST;
        end
    end
endmodule

// File: rtl/aes_stream_if.sv
// aes_stream_if: assembles plaintext/key bytes into blocks for aes_core, launches it,
// and streams the ciphertext back out byte by byte.
module aes_stream_if
    import aes_pkg::*;
#(
    parameter int BLK_BYTES = AES_BLK_BYTES,
    parameter int WAIT_MAX  = 31
) (
    input  logic       sclk,
    input  logic       srst_n,
    input  logic [7:0] in_data,
    input  logic       in_key,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       core_en,
    output logic [7:0] core_text [BLK_BYTES-1:0],
    output logic [7:0] core_key  [BLK_BYTES-1:0],
    input  logic       core_valid,
    input  logic [7:0] core_val  [BLK_BYTES-1:0],
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_last,
    input  logic       out_ready,
    output logic       busy,
    output logic       key_ok,
    output logic       timeout_err
);
    localparam int KW = $clog2(BLK_BYTES);
    localparam int TW = $clog2(BLK_BYTES + 1);
    localparam int WW = $clog2(WAIT_MAX + 1);
    localparam logic [KW-1:0] KEY_LAST  = KW'(BLK_BYTES - 1);
    localparam logic [TW-1:0] TXT_LAST  = TW'(BLK_BYTES - 1);
    localparam logic [TW-1:0] TXT_FULL  = TW'(BLK_BYTES);
    localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_MAX - 1);

    st_e           state, nxt;
    logic          live;
    logic [TW-1:0] txt_cnt;
    logic [KW-1:0] key_cnt;
    logic [WW-1:0] wait_cnt;
    block_t        txt_reg, key_reg;
    logic          acc, acc_key, acc_txt, key_wrap, go, timeout, ser_load, ser_done;

    assign core_text = txt_reg;
    assign core_key  = key_reg;

    // A full text block waits for the key to be complete; meanwhile only key bytes are taken.
    always_comb begin
        in_ready = live && state == LOAD && (in_key || txt_cnt != TXT_FULL);
        acc      = in_valid && in_ready;
        acc_key  = acc && in_key;
        acc_txt  = acc && !in_key;
        key_wrap = acc_key && key_cnt == KEY_LAST;
        go       = (acc_txt && txt_cnt == TXT_LAST && key_ok && key_cnt == '0) ||
                   (key_wrap && txt_cnt == TXT_FULL);
        timeout  = state == WAIT && !core_valid && wait_cnt == WAIT_LAST;
        ser_load = state == WAIT && core_valid;
        nxt      = state == LOAD  ? (go ? ISSUE : LOAD) :
                   state == ISSUE ? WAIT :
                   state == WAIT  ? (core_valid ? DRAIN : timeout ? LOAD : WAIT) :
                                    (ser_done ? LOAD : DRAIN);
    end

    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) state <= LOAD;
        else         state <= nxt;
    end

    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            live        <= 1'b0;
            core_en     <= 1'b0;
            busy        <= 1'b0;
            key_ok      <= 1'b0;
            timeout_err <= 1'b0;
            txt_cnt     <= '0;
            key_cnt     <= '0;
            wait_cnt    <= '0;
            txt_reg     <= '{default: '0};
            key_reg     <= '{default: '0};
        end else begin
            live     <= 1'b1;
            core_en  <= nxt == ISSUE;
            busy     <= nxt != LOAD;
            wait_cnt <= state == WAIT ? wait_cnt + 1'b1 : '0;
            txt_cnt  <= go ? '0 : txt_cnt + TW'(acc_txt);
            if (acc_txt) txt_reg[txt_cnt[KW-1:0]] <= in_data;
            if (acc_key) begin
                key_reg[key_cnt] <= in_data;
                key_cnt          <= key_wrap ? '0 : key_cnt + 1'b1;
            end
            if (key_wrap) key_ok <= 1'b1;
            if (timeout) timeout_err <= 1'b1;
        end
    end

    aes_block_ser u_ser (
        .sclk      (sclk),
        .srst_n    (srst_n),
        .load      (ser_load),
        .blk       (core_val),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .done      (ser_done)
    );
endmodule

// File: tb/tb_aes_stream_if.sv
// tb_aes_stream_if: randomized bench for aes_stream_if with a behavioural stub core and block-level reference.
module tb_aes_stream_if;
    logic       sclk = 1'b0;
    logic       srst_n = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_key = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       core_en;
    logic [7:0] core_text [15:0];
    logic [7:0] core_key  [15:0];
    logic       core_valid = 1'b0;
    logic [7:0] core_val  [15:0] = '{default: 8'h00};
    logic [7:0] out_data;
    logic       out_valid, out_last;
    logic       out_ready = 1'b1;
    logic       busy, key_ok, timeout_err;

    aes_stream_if dut (
        .sclk(sclk), .srst_n(srst_n), .in_data(in_data), .in_key(in_key), .in_valid(in_valid),
        .in_ready(in_ready), .core_en(core_en), .core_text(core_text), .core_key(core_key),
        .core_valid(core_valid), .core_val(core_val), .out_data(out_data), .out_valid(out_valid),
        .out_last(out_last), .out_ready(out_ready), .busy(busy), .key_ok(key_ok),
        .timeout_err(timeout_err)
    );

    always #5 sclk = ~sclk;

    int pass_n = 0, chk_n = 0, stall_to = 0;
    int en_cnt = 0, cv_cnt = 0, pend = 0;
    logic         stub_on = 1'b1;
    logic [127:0] st_v = '0;
    logic [127:0] cur_key;
    logic [8:0]   got_q [$];
    logic [127:0] fips_key = 128'h0f0e0d0c0b0a09080706050403020100;
    logic [127:0] fips_pt  = 128'hffeeddccbbaa99887766554433221100;
    logic [127:0] fips_ct  = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
    logic [127:0] ct_p, ck_p;

    for (genvar g = 0; g < 16; g++) begin : g_pack
        assign ct_p[8*g +: 8] = core_text[g];
        assign ck_p[8*g +: 8] = core_key[g];
    end

    // Byte i of a packed block lives at [8*i +: 8]; FIPS-197 C.1 is answered exactly, anything else by a keyed mix.
    function automatic logic [127:0] ref_blk(input logic [127:0] t, input logic [127:0] k);
        logic [127:0] r;
        if (t == fips_pt && k == fips_key) return fips_ct;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = t[8*i +: 8] ^ k[8*(15-i) +: 8] ^ 8'(i * 29 + 3);
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    always @(posedge sclk) begin
        core_valid <= 1'b0;
        if (core_en && stub_on) begin
            pend <= 12;
            st_v <= ref_blk(ct_p, ck_p);
        end else if (pend > 0) begin
            pend <= pend - 1;
            if (pend == 1) begin
                core_valid <= 1'b1;
                for (int i = 0; i < 16; i++) core_val[i] <= st_v[8*i +: 8];
            end
        end
    end

    always @(posedge sclk) begin
        if (core_en) en_cnt <= en_cnt + 1;
        if (core_valid) cv_cnt <= cv_cnt + 1;
        if (out_valid && out_ready) got_q.push_back({out_last, out_data});
    end

    task automatic send(input logic k, input logic [7:0] d);
        logic ok;
        ok = 1'b0;
        in_key = k; in_data = d; in_valid = 1'b1;
        for (int c = 0; c < 200 && !ok; c++) begin
            #1 ok = in_ready;
            @(negedge sclk);
        end
        if (!ok) stall_to++;
    endtask

    task automatic send_blk(input logic k, input logic [127:0] v);
        for (int i = 0; i < 16; i++) send(k, v[8*i +: 8]);
    endtask

    task automatic test_reset;
        srst_n = 1'b0;
        repeat (2) @(negedge sclk);
        chk_n++; if ({in_ready, core_en, out_valid, out_last, busy, key_ok, timeout_err} !== 7'b0)
            $display("FAIL rst_flags got %b want 0000000", {in_ready, core_en, out_valid, out_last, busy, key_ok, timeout_err}); else pass_n++;
        chk_n++; if (out_data !== 8'h00) $display("FAIL rst_out_data got %h want 00", out_data); else pass_n++;
        srst_n = 1'b1;
        #1;
        chk_n++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready_release got %b want 0", in_ready); else pass_n++;
        @(negedge sclk);
        chk_n++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready_rise got %b want 1", in_ready); else pass_n++;
    endtask

    task automatic test_fips;
        int base, e0;
        logic [8:0] g, e;
        base = got_q.size(); e0 = en_cnt;
        send_blk(1'b1, fips_key);
        send_blk(1'b0, fips_pt);
        in_valid = 1'b0;
        cur_key = fips_key;
        for (int c = 0; c < 300 && got_q.size() < base + 16; c++) @(negedge sclk);
        repeat (4) @(negedge sclk);
        chk_n++; if (got_q.size() !== base + 16) $display("FAIL fips_count got %0d want %0d", got_q.size() - base, 16); else pass_n++;
        chk_n++; if (en_cnt - e0 !== 1) $display("FAIL fips_en_pulses got %0d want 1", en_cnt - e0); else pass_n++;
        chk_n++; if (key_ok !== 1'b1) $display("FAIL fips_key_ok got %b want 1", key_ok); else pass_n++;
        for (int i = 0; i < 16; i++) begin
            e = {i == 15, fips_ct[8*i +: 8]};
            g = got_q.size() > base + i ? got_q[base + i] : 9'bx;
            chk_n++; if (g !== e) $display("FAIL fips_byte%0d got %h want %h", i, g, e); else pass_n++;
        end
    endtask

    task automatic test_back_to_back;
        logic [127:0] p1, p2, e1, e2;
        logic [8:0] g, e;
        int base, e0, viol;
        logic inwin, closed;
        p1 = rnd128(); p2 = rnd128();
        e1 = ref_blk(p1, cur_key); e2 = ref_blk(p2, cur_key);
        base = got_q.size(); e0 = en_cnt; viol = 0; inwin = 1'b0; closed = 1'b0;
        fork
            begin
                send_blk(1'b0, p1);
                send_blk(1'b0, p2);
                in_valid = 1'b0;
            end
            for (int c = 0; c < 600 && !closed; c++) begin
                @(negedge sclk);
                #2;
                if (core_en) inwin = 1'b1;
                if (inwin && in_ready) viol++;
                if (inwin && out_valid && out_ready && out_last) closed = 1'b1;
            end
        join
        for (int c = 0; c < 300 && got_q.size() < base + 32; c++) @(negedge sclk);
        repeat (4) @(negedge sclk);
        chk_n++; if (closed !== 1'b1 || viol !== 0) $display("FAIL b2b_in_ready_window got closed=%b viol=%0d want closed=1 viol=0", closed, viol); else pass_n++;
        chk_n++; if (en_cnt - e0 !== 2) $display("FAIL b2b_en_pulses got %0d want 2", en_cnt - e0); else pass_n++;
        chk_n++; if (got_q.size() !== base + 32) $display("FAIL b2b_count got %0d want 32", got_q.size() - base); else pass_n++;
        for (int i = 0; i < 32; i++) begin
            e = i < 16 ? {i == 15, e1[8*i +: 8]} : {i == 31, e2[8*(i-16) +: 8]};
            g = got_q.size() > base + i ? got_q[base + i] : 9'bx;
            chk_n++; if (g !== e) $display("FAIL b2b_byte%0d got %h want %h", i, g, e); else pass_n++;
        end
    endtask

    task automatic test_partial_key;
        logic [127:0] pt, k2, pt3, k3, used, ex;
        logic [8:0] g, e;
        int base, stall, ti, ki;
        srst_n = 1'b0;
        @(negedge sclk);
        srst_n = 1'b1;
        @(negedge sclk);
        pt = rnd128(); k2 = rnd128(); base = got_q.size();
        send_blk(1'b0, pt);
        in_key = 1'b0; in_data = 8'($urandom()); stall = 0;
        repeat (4) begin
            #1 if (in_ready) stall++;
            @(negedge sclk);
        end
        chk_n++; if (stall !== 0) $display("FAIL pk_text_stall got %0d ready cycles want 0", stall); else pass_n++;
        for (int i = 0; i < 15; i++) send(1'b1, k2[8*i +: 8]);
        chk_n++; if (core_en !== 1'b0 || key_ok !== 1'b0) $display("FAIL pk_early_issue got en=%b key_ok=%b want 0 0", core_en, key_ok); else pass_n++;
        send(1'b1, k2[127:120]);
        in_valid = 1'b0;
        chk_n++; if (core_en !== 1'b1) $display("FAIL pk_issue_after_key got %b want 1", core_en); else pass_n++;
        for (int c = 0; c < 300 && got_q.size() < base + 16; c++) @(negedge sclk);
        ex = ref_blk(pt, k2);
        for (int i = 0; i < 16; i++) begin
            e = {i == 15, ex[8*i +: 8]};
            g = got_q.size() > base + i ? got_q[base + i] : 9'bx;
            chk_n++; if (g !== e) $display("FAIL pk_byte%0d got %h want %h", i, g, e); else pass_n++;
        end
        // Interleaved: the block takes the old key only if no new key byte preceded its 16th text byte.
        pt3 = rnd128(); k3 = rnd128(); ti = 0; ki = 0; used = k3;
        base = got_q.size();
        while (ti < 16 || ki < 16) begin
            if (ki < 16 && (ti == 16 || $urandom_range(0, 1) == 1)) begin
                send(1'b1, k3[8*ki +: 8]); ki++;
            end else begin
                send(1'b0, pt3[8*ti +: 8]); ti++;
                if (ti == 16) used = ki == 0 ? k2 : k3;
            end
        end
        in_valid = 1'b0;
        cur_key = k3;
        for (int c = 0; c < 300 && got_q.size() < base + 16; c++) @(negedge sclk);
        ex = ref_blk(pt3, used);
        for (int i = 0; i < 16; i++) begin
            e = {i == 15, ex[8*i +: 8]};
            g = got_q.size() > base + i ? got_q[base + i] : 9'bx;
            chk_n++; if (g !== e) $display("FAIL mix_byte%0d got %h want %h", i, g, e); else pass_n++;
        end
    endtask

    task automatic test_out_ready;
        logic [127:0] pt, ex;
        logic [8:0] g, e;
        logic pv, pr;
        logic [7:0] pd;
        int base, bad;
        pt = rnd128(); ex = ref_blk(pt, cur_key);
        base = got_q.size(); bad = 0; pv = 1'b0; pr = 1'b1; pd = 8'h00;
        send_blk(1'b0, pt);
        in_valid = 1'b0;
        for (int c = 0; c < 400 && got_q.size() < base + 16; c++) begin
            if (pv && !pr && (out_valid !== 1'b1 || out_data !== pd)) bad++;
            pv = out_valid; pd = out_data;
            out_ready = $urandom_range(0, 1) == 1;
            pr = out_ready;
            @(negedge sclk);
        end
        out_ready = 1'b1;
        repeat (4) @(negedge sclk);
        chk_n++; if (bad !== 0) $display("FAIL ordy_stable got %0d unstable cycles want 0", bad); else pass_n++;
        chk_n++; if (got_q.size() !== base + 16) $display("FAIL ordy_count got %0d want 16", got_q.size() - base); else pass_n++;
        for (int i = 0; i < 16; i++) begin
            e = {i == 15, ex[8*i +: 8]};
            g = got_q.size() > base + i ? got_q[base + i] : 9'bx;
            chk_n++; if (g !== e) $display("FAIL ordy_byte%0d got %h want %h", i, g, e); else pass_n++;
        end
    endtask

    task automatic test_timeout;
        logic [127:0] pt, ex;
        logic [8:0] g, e;
        int base;
        stub_on = 1'b0;
        send_blk(1'b0, rnd128());
        in_valid = 1'b0;
        chk_n++; if (core_en !== 1'b1) $display("FAIL to_issue got %b want 1", core_en); else pass_n++;
        repeat (31) @(negedge sclk);
        chk_n++; if (timeout_err !== 1'b0) $display("FAIL to_early got %b want 0", timeout_err); else pass_n++;
        @(negedge sclk);
        chk_n++; if (timeout_err !== 1'b1) $display("FAIL to_set got %b want 1", timeout_err); else pass_n++;
        chk_n++; if (busy !== 1'b0 || in_ready !== 1'b1) $display("FAIL to_back_to_load got busy=%b in_ready=%b want 0 1", busy, in_ready); else pass_n++;
        stub_on = 1'b1;
        pt = rnd128(); ex = ref_blk(pt, cur_key); base = got_q.size();
        send_blk(1'b0, pt);
        in_valid = 1'b0;
        for (int c = 0; c < 300 && got_q.size() < base + 16; c++) @(negedge sclk);
        for (int i = 0; i < 16; i++) begin
            e = {i == 15, ex[8*i +: 8]};
            g = got_q.size() > base + i ? got_q[base + i] : 9'bx;
            chk_n++; if (g !== e) $display("FAIL to_next_byte%0d got %h want %h", i, g, e); else pass_n++;
        end
        chk_n++; if (timeout_err !== 1'b1) $display("FAIL to_sticky got %b want 1", timeout_err); else pass_n++;
    endtask

    task automatic test_reset_wait;
        int base, cv0;
        stub_on = 1'b1;
        send_blk(1'b0, rnd128());
        in_valid = 1'b0;
        repeat (5) @(negedge sclk);
        cv0 = cv_cnt;
        chk_n++; if (busy !== 1'b1) $display("FAIL rw_busy_in_wait got %b want 1", busy); else pass_n++;
        srst_n = 1'b0;
        #1;
        chk_n++; if ({in_ready, core_en, out_valid, out_last, busy, key_ok, timeout_err} !== 7'b0)
            $display("FAIL rw_async_flags got %b want 0000000", {in_ready, core_en, out_valid, out_last, busy, key_ok, timeout_err}); else pass_n++;
        chk_n++; if (out_data !== 8'h00) $display("FAIL rw_out_data got %h want 00", out_data); else pass_n++;
        @(negedge sclk);
        srst_n = 1'b1;
        base = got_q.size();
        repeat (30) @(negedge sclk);
        chk_n++; if (cv_cnt - cv0 !== 1) $display("FAIL rw_stub_pulse got %0d want 1", cv_cnt - cv0); else pass_n++;
        chk_n++; if (got_q.size() !== base || out_valid !== 1'b0) $display("FAIL rw_no_output got %0d bytes valid=%b want 0 0", got_q.size() - base, out_valid); else pass_n++;
        chk_n++; if (key_ok !== 1'b0 || busy !== 1'b0) $display("FAIL rw_after got key_ok=%b busy=%b want 0 0", key_ok, busy); else pass_n++;
    endtask

    task automatic test_no_stall;
        chk_n++; if (stall_to !== 0) $display("FAIL send_timeouts got %0d want 0", stall_to); else pass_n++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired after %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        cur_key = fips_key;
        @(negedge sclk);
        test_reset();
        test_fips();
        test_back_to_back();
        test_partial_key();
        test_out_ready();
        test_timeout();
        test_reset_wait();
        test_no_stall();
        $display("%0d/%0d checks passed", pass_n, chk_n);
        $finish;
    end
endmodule
